// File: rtl/uart_tx_core.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense set by PARITY_ODD).
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TXD,
  output logic       BUSY,
  output logic       DONE
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_param_check
    $error("uart_tx_core: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [2:0]          bit_cnt, bit_n;
  logic [7:0]          shift_reg, shift_n;
  logic                txd_n, ready_n, done_n;
  logic                baud_end;

`ifdef UART_TX_PARITY_EN
  logic                par_bit, par_n;

  // Parity is fixed at acceptance so the shifting data register need not be tracked.
  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ 1'(PARITY_ODD);
  endfunction
`endif

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    txd_n   = TXD;
    ready_n = READY;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_bit;
`endif
    case (state)
      ST_IDLE: begin
        txd_n   = 1'b1;
        ready_n = 1'b1;
        if (VALID && READY) begin
          shift_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_START;
          txd_n   = 1'b0;
          ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n   = parity_of(DATA);
`endif
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = ST_DATA;
          txd_n   = shift_reg[0];
        end else begin
          baud_n  = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            txd_n   = par_bit;
`else
            state_n = ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + 3'd1;
            txd_n   = shift_reg[1];
          end
        end else begin
          baud_n  = baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end else begin
          baud_n  = baud_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        txd_n = 1'b1;
        if (baud_end) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            state_n = ST_IDLE;
            ready_n = 1'b1;
            done_n  = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        txd_n   = 1'b1;
        ready_n = 1'b1;
      end
    endcase
  end

  // All outputs come straight from flops; BUSY is kept as a separate copy of ~READY.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      TXD       <= 1'b1;
      READY     <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      TXD       <= txd_n;
      READY     <= ready_n;
      BUSY      <= ~ready_n;
      DONE      <= done_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) par_bit <= 1'b0;
    else        par_bit <= par_n;
  end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: three instances (1 stop bit even parity sense,
// 2 stop bits, odd parity sense) sharing clock and reset, all at 4 clocks per bit.
module tb_uart_tx_core;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] data [3];
  logic [2:0] ready, txd, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_s1 (
    .CLK(clk), .RESET(reset), .DATA(data[0]), .VALID(valid[0]),
    .READY(ready[0]), .TXD(txd[0]), .BUSY(busy[0]), .DONE(done[0]));

  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_s2 (
    .CLK(clk), .RESET(reset), .DATA(data[1]), .VALID(valid[1]),
    .READY(ready[1]), .TXD(txd[1]), .BUSY(busy[1]), .DONE(done[1]));

  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_odd (
    .CLK(clk), .RESET(reset), .DATA(data[2]), .VALID(valid[2]),
    .READY(ready[2]), .TXD(txd[2]), .BUSY(busy[2]), .DONE(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Caller is positioned 1 time unit after the acceptance edge.
  task automatic run_frame(input int d, input logic [7:0] b, input int stops, input logic odd);
    logic [15:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    nb = 9;
    if (PAR == 1) begin
      bits[9] = (^b) ^ odd;
      nb = 10;
    end
    nb += stops;
    for (int k = 0; k < nb * CPB; k++) begin
      check($sformatf("d%0d_%0h_txd_bit%0d_cyc%0d", d, b, k / CPB, k), 32'(txd[d]), 32'(bits[k / CPB]));
      check($sformatf("d%0d_%0h_done_cyc%0d", d, b, k), 32'(done[d]), 32'd0);
      if (k % CPB == 0) begin
        check($sformatf("d%0d_%0h_busy_cyc%0d", d, b, k), 32'(busy[d]), 32'd1);
        check($sformatf("d%0d_%0h_ready_cyc%0d", d, b, k), 32'(ready[d]), 32'd0);
      end
      @(posedge clk); #1;
    end
    check($sformatf("d%0d_%0h_done_end", d, b), 32'(done[d]), 32'd1);
    check($sformatf("d%0d_%0h_ready_end", d, b), 32'(ready[d]), 32'd1);
    check($sformatf("d%0d_%0h_busy_end", d, b), 32'(busy[d]), 32'd0);
    check($sformatf("d%0d_%0h_txd_end", d, b), 32'(txd[d]), 32'd1);
  endtask

  task automatic accept(input int d, input logic [7:0] b);
    check($sformatf("d%0d_ready_before_accept", d), 32'(ready[d]), 32'd1);
    data[d]  = b;
    valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic done_drops(input int d);
    @(posedge clk); #1;
    check($sformatf("d%0d_done_one_cycle", d), 32'(done[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    valid = '0;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    #12;
    check("rst_txd",   32'(txd),   32'b111);
    check("rst_ready", 32'(ready), 32'b111);
    check("rst_busy",  32'(busy),  32'b000);
    check("rst_done",  32'(done),  32'b000);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_txd", 32'(txd), 32'b111);

    // 0x55, one stop bit
    accept(0, 8'h55);
    run_frame(0, 8'h55, 1, 1'b0);
    done_drops(0);

    // 0x07 parity sense, even then odd
    accept(0, 8'h07);
    run_frame(0, 8'h07, 1, 1'b0);
    done_drops(0);
    accept(2, 8'h07);
    run_frame(2, 8'h07, 1, 1'b1);
    done_drops(2);

    // VALID held high: back-to-back 0xA5 then 0x3C, DATA change mid-frame ignored
    data[0]  = 8'hA5;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    data[0]  = 8'h3C;
    run_frame(0, 8'hA5, 1, 1'b0);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    check("b2b_second_start_txd", 32'(txd[0]), 32'd0);
    run_frame(0, 8'h3C, 1, 1'b0);
    done_drops(0);

    // 0x12 offered while 0x81 is in flight is dropped
    accept(0, 8'h81);
    fork
      run_frame(0, 8'h81, 1, 1'b0);
      begin
        repeat (8) @(posedge clk);
        #2;
        data[0]  = 8'h12;
        valid[0] = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        valid[0] = 1'b0;
      end
    join
    for (int k = 0; k < 3 * CPB; k++) begin
      @(posedge clk); #1;
      check($sformatf("ignored_txd_idle_cyc%0d", k), 32'(txd[0]), 32'd1);
      check($sformatf("ignored_ready_cyc%0d", k), 32'(ready[0]), 32'd1);
    end

    // 0x00 with two stop bits
    accept(1, 8'h00);
    run_frame(1, 8'h00, 2, 1'b0);
    done_drops(1);

    // Reset during data bit 3 aborts the frame; 0xFF then goes out normally
    accept(0, 8'h00);
    repeat (17) @(posedge clk);
    #1;
    check("abort_txd_bit3", 32'(txd[0]), 32'd0);
    check("abort_busy_bit3", 32'(busy[0]), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_txd",   32'(txd[0]),   32'd1);
    check("abort_ready", 32'(ready[0]), 32'd1);
    check("abort_busy",  32'(busy[0]),  32'd0);
    check("abort_done",  32'(done[0]),  32'd0);
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    check("in_reset_no_accept_txd", 32'(txd[0]), 32'd1);
    check("in_reset_no_done",       32'(done[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    run_frame(0, 8'hFF, 1, 1'b0);
    done_drops(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning CLK cycles per serial bit; legal values are 2 and above.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values are 1 or 2.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 = even, 1 = odd); used only when parity is compiled in.
REQ-004 SHALL have port CLK, input, 1 bit: system clock; all logic on rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port DATA, input, 8 bits: byte to transmit; sampled only on acceptance.
REQ-007 SHALL have port VALID, input, 1 bit: DATA is offered for transmission.
REQ-008 SHALL have port READY, output, 1 bit: block can accept a byte this cycle.
REQ-009 SHALL have port TXD, output, 1 bit: serial line; idle level is 1.
REQ-010 SHALL have port BUSY, output, 1 bit: a frame is in progress (logical inverse of READY).
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY and STOP; an unused encoding SHALL go to IDLE on the next edge.
REQ-013 SHALL assert READY only in IDLE; a byte is accepted on a rising edge where VALID=1 and READY=1.
REQ-014 SHALL, on acceptance, latch DATA into the shift register, clear the bit counter and baud counter, and enter START; TXD=0 from the next cycle.
REQ-015 SHALL hold each bit for exactly CLKS_PER_BIT cycles; the baud counter restarts at every acceptance, with no free-running phase.
REQ-016 SHALL send data LSB first, 8 bits, in DATA state, then PARITY (if compiled in), then STOP_BITS stop bits of 1.
REQ-017 SHALL, after the final stop-bit period, enter IDLE; in the first IDLE cycle READY=1, BUSY=0 and DONE=1 for exactly one cycle.
REQ-018 SHALL drive TXD=1 in IDLE; the minimum inter-frame gap is therefore one CLK beyond the stop bits when VALID is held high.
REQ-019 SHALL ignore VALID and DATA changes while BUSY=1; no queuing, and the ignored byte is not sent.
REQ-020 SHALL register TXD, READY, BUSY and DONE directly from flops, with no combinational path from VALID or DATA.
REQ-021 SHALL size the baud counter as clog2(CLKS_PER_BIT) bits and the bit counter as 3 bits; no overflow is permitted at the legal limits.

Reset
REQ-022 SHALL, on RESET=0, immediately set TXD=1, READY=1, BUSY=0, DONE=0, state IDLE, and all counters and the shift register to 0.
REQ-023 SHALL treat reset asserted mid-frame as an abort: the partial frame is truncated, no DONE is produced, and normal acceptance resumes on the first edge after release.

Configuration
REQ-024 SHALL compile in the PARITY state and its parity bit only when macro UART_TX_PARITY_EN is defined.
REQ-025 SHALL, with UART_TX_PARITY_EN defined, send one parity bit after data bit 7. With PARITY_ODD=0, the XOR of the 8 data bits and the parity bit equals 0. With PARITY_ODD=1, that XOR equals 1.
REQ-026 SHALL, without UART_TX_PARITY_EN, go directly from DATA to STOP and ignore PARITY_ODD; the frame is 9+STOP_BITS bit periods.

Verification (CLKS_PER_BIT=4, acceptance edge = t0)
REQ-027 SHALL cover: no parity, STOP_BITS=1, send 0x55 -> TXD 0,1,0,1,0,1,0,1,0,1, each held 4 cycles from t0+1; DONE=1 only at t0+41.
REQ-028 SHALL cover: UART_TX_PARITY_EN defined, 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; DONE at t0+45.
REQ-029 SHALL cover: VALID held high with 0xA5 then 0x3C -> second acceptance at t0+41, second start bit at t0+42, both bytes correct on TXD.
REQ-030 SHALL cover: RESET pulsed low during data bit 3 -> TXD=1 immediately, no DONE; the next frame with 0xFF is transmitted correctly.
REQ-031 SHALL cover: VALID=1 with DATA=0x12 during a busy frame of 0x81 -> only 0x81 is transmitted, and 0x12 is never sent.
REQ-032 SHALL cover: STOP_BITS=2, no parity, 0x00 -> TXD=0 for 36 cycles and then 1 for 8 cycles; DONE at t0+45.
